// File: rtl/axi_lite_capture_pkg.sv
// axi_lite_capture_pkg: register map, CTRL bit positions and response codes.
// Revision 1.0
`default_nettype none

package axi_lite_capture_pkg;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DATA    = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_CLEAR  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with flush; full is judged before any same-cycle pop.
// Revision 1.0
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             w_push;
   logic             w_pop;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   assign w_push = push & ~full & ~flush;
   assign w_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (w_push && !w_pop)      count_q <= count_q + 1'b1;
         else if (w_pop && !w_push) count_q <= count_q - 1'b1;
      end
   end

   // Storage carries no reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/axi_lite_capture_slave.sv
// axi_lite_capture_slave: AXI4-Lite register slave (CTRL/STATUS/DATA/SCRATCH) draining a capture FIFO.
// Revision 1.0
`default_nettype none

module axi_lite_capture_slave
   import axi_lite_capture_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            cap_valid,
   input  logic [31:0]                     cap_data,
   output logic                            irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic        live_q;
   logic        aw_held_q, w_held_q, bvalid_q, rvalid_q;
   logic [1:0]  awreg_q;
   logic [31:0] wdata_q, rdata_q, scratch_q;
   logic [3:0]  wstrb_q;
   logic        enable_q, irq_en_q, ovf_q;

   logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_ctrl_wr, w_clear, w_pop;
   logic [1:0]  w_arreg;
   logic [31:0] w_rdata_d, scratch_d, w_dout;
   logic        enable_d, irq_en_d;
   logic [CW-1:0] w_count;
   logic [15:0] w_cnt16;
   logic        w_full, w_empty;
   logic        w_unused;

   // READYs are held low until the first edge after reset release.
   assign S_AXI_AWREADY = live_q & ~aw_held_q & ~bvalid_q;
   assign S_AXI_WREADY  = live_q & ~w_held_q & ~bvalid_q;
   assign S_AXI_ARREADY = live_q & ~rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign irq           = irq_en_q & ~w_empty;

   assign w_aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_w_hs    = S_AXI_WVALID & S_AXI_WREADY;
   assign w_ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
   assign w_arreg   = S_AXI_ARADDR[3:2];
   assign w_commit  = aw_held_q & w_held_q;
   assign w_ctrl_wr = w_commit & (awreg_q == REG_CTRL) & wstrb_q[0];
   assign w_clear   = w_ctrl_wr & wdata_q[CTRL_CLEAR];
   assign w_pop     = w_ar_hs & (w_arreg == REG_DATA);
   assign w_cnt16   = 16'(w_count);
   assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_comb begin
      enable_d  = w_ctrl_wr ? wdata_q[CTRL_ENABLE] : enable_q;
      irq_en_d  = w_ctrl_wr ? wdata_q[CTRL_IRQ_EN] : irq_en_q;
      scratch_d = scratch_q;
      if (w_commit && awreg_q == REG_SCRATCH) scratch_d = apply_wstrb(scratch_q, wdata_q, wstrb_q);
      w_rdata_d = '0;
      case (w_arreg)
         REG_CTRL:    w_rdata_d = {29'd0, irq_en_q, 1'b0, enable_q};
         REG_STATUS:  w_rdata_d = {w_cnt16, 13'd0, ovf_q, w_full, w_empty};
         REG_DATA:    w_rdata_d = w_empty ? 32'd0 : w_dout;
         default:     w_rdata_d = scratch_q;
      endcase
   end

   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .push  (enable_q & cap_valid),
      .din   (cap_data),
      .pop   (w_pop),
      .flush (w_clear),
      .dout  (w_dout),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         live_q    <= 1'b0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         awreg_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         scratch_q <= '0;
         enable_q  <= 1'b0;
         irq_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (w_aw_hs) begin
            aw_held_q <= 1'b1;
            awreg_q   <= S_AXI_AWADDR[3:2];
         end
         if (w_w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
         end
         if (w_commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
         end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end
         enable_q  <= enable_d;
         irq_en_q  <= irq_en_d;
         scratch_q <= scratch_d;
         if (w_clear) ovf_q <= 1'b0;
         else if (enable_q && cap_valid && w_full) ovf_q <= 1'b1;
         if (w_ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= w_rdata_d;
         end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_capture_slave.sv
// tb_axi_lite_capture_slave: directed AXI4-Lite sequence with read scoreboard and FIFO model.
// Revision 1.0
`default_nettype none

module tb_axi_lite_capture_slave;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [3:0]  AWADDR, ARADDR;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] WDATA, RDATA, cap_data;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;
   logic        cap_valid, irq;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] sb_q[$];
   string       sb_tag[$];
   logic [31:0] mdl[$];
   bit          m_en = 1'b0;

   always #5 ACLK = ~ACLK;

   axi_lite_capture_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
      .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
      .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
      .cap_valid(cap_valid), .cap_data(cap_data), .irq(irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic [31:0] pop_model();
      if (mdl.size() == 0) return 32'd0;
      return mdl.pop_front();
   endfunction

   task automatic cap_push(input logic [31:0] d);
      cap_valid = 1'b1;
      cap_data  = d;
      if (m_en && mdl.size() < 16) mdl.push_back(d);
      tick();
      cap_valid = 1'b0;
   endtask

   task automatic wait_b(input string tag);
      int k = 0;
      BREADY = 1'b1;
      while (!BVALID && k < 20) begin tick(); k++; end
      check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
      check({tag, "_bresp"}, 32'(BRESP), 32'd0);
      tick();
      BREADY = 1'b0;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit aw_done = 1'b0, w_done = 1'b0, awhs, whs;
      AWADDR = addr; WDATA = data; WSTRB = strb;
      AWVALID = 1'b1; WVALID = 1'b1;
      for (int k = 0; k < 20 && !(aw_done && w_done); k++) begin
         awhs = AWVALID && AWREADY;
         whs  = WVALID && WREADY;
         tick();
         if (awhs) begin AWVALID = 1'b0; aw_done = 1'b1; end
         if (whs)  begin WVALID = 1'b0;  w_done = 1'b1;  end
      end
      if (!(aw_done && w_done)) check("aw_w_timeout", 32'd0, 32'd1);
      AWVALID = 1'b0; WVALID = 1'b0;
      wait_b("wr");
   endtask

   task automatic ar_issue(input logic [3:0] addr);
      int k = 0;
      ARADDR = addr; ARVALID = 1'b1;
      while (!ARREADY && k < 20) begin tick(); k++; end
      if (!ARREADY) check("arready_timeout", 32'd0, 32'd1);
      tick();
      ARVALID = 1'b0;
   endtask

   task automatic r_collect(input int stall);
      int k = 0;
      logic [31:0] first, exp;
      string tag;
      RREADY = 1'b0;
      while (!RVALID && k < 20) begin tick(); k++; end
      first = RDATA;
      for (int s = 0; s < stall; s++) begin
         tick();
         check("rvalid_hold", 32'(RVALID), 32'd1);
         check("rdata_stable", RDATA, first);
         check("arready_blocked", 32'(ARREADY), 32'd0);
      end
      RREADY = 1'b1;
      exp = sb_q.pop_front();
      tag = sb_tag.pop_front();
      check({tag, "_rvalid"}, 32'(RVALID), 32'd1);
      check(tag, RDATA, exp);
      check({tag, "_rresp"}, 32'(RRESP), 32'd0);
      tick();
      RREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
      sb_q.push_back(exp);
      sb_tag.push_back(tag);
      ar_issue(addr);
      r_collect(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESETN = 1'b0; AWADDR = '0; ARADDR = '0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARVALID = 1'b0; RREADY = 1'b0; WDATA = '0; WSTRB = '0; cap_valid = 1'b0; cap_data = '0;
      repeat (3) tick();
      check("rst_bvalid", 32'(BVALID), 32'd0);
      check("rst_rvalid", 32'(RVALID), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
      ARESETN = 1'b1;
      repeat (2) tick();
      axi_read(4'h4, 32'h0000_0001, "rst_status");
      axi_read(4'h0, 32'h0000_0000, "rst_ctrl");
      axi_read(4'hC, 32'h0000_0000, "rst_scratch");

      for (int i = 1; i <= 4; i++) begin
         axi_write(4'hC, 32'(i), 4'hF);
         axi_read(4'hC, 32'(i), "scratch_rw");
      end
      axi_write(4'hC, 32'hAABB_CCDD, 4'b0010);
      axi_read(4'hC, 32'h0000_CC04, "scratch_wstrb");

      axi_write(4'h0, 32'h0000_0005, 4'hF);
      m_en = 1'b1;
      axi_read(4'h0, 32'h0000_0005, "ctrl_rb");
      cap_push(32'h11); cap_push(32'h22); cap_push(32'h33);
      axi_read(4'h4, 32'h0003_0000, "status_3");
      check("irq_set", 32'(irq), 32'd1);
      for (int i = 0; i < 3; i++) axi_read(4'h8, pop_model(), "data_drain");
      axi_read(4'h4, 32'h0000_0001, "status_empty");
      check("irq_clr", 32'(irq), 32'd0);
      axi_read(4'h8, 32'h0000_0000, "data_empty");

      for (int i = 1; i <= 17; i++) cap_push(32'(i));
      axi_read(4'h4, 32'h0010_0006, "status_ovf");
      for (int i = 0; i < 16; i++) axi_read(4'h8, pop_model(), "ovf_drain");
      axi_read(4'h4, 32'h0000_0005, "status_sticky");
      axi_write(4'h0, 32'h0000_0003, 4'hF);
      mdl.delete();
      axi_read(4'h4, 32'h0000_0001, "status_cleared");
      axi_read(4'h0, 32'h0000_0001, "ctrl_clear_rd0");

      AWADDR = 4'hC; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
      check("wready_pre", 32'(WREADY), 32'd1);
      tick();
      WVALID = 1'b0;
      check("wready_held", 32'(WREADY), 32'd0);
      tick(); tick();
      check("awready_wfirst", 32'(AWREADY), 32'd1);
      check("bvalid_early", 32'(BVALID), 32'd0);
      AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      check("bvalid_pre_commit", 32'(BVALID), 32'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bvalid_stall", 32'(BVALID), 32'd1);
         check("awready_stall", 32'(AWREADY), 32'd0);
         tick();
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      check("bvalid_done", 32'(BVALID), 32'd0);
      check("awready_back", 32'(AWREADY), 32'd1);
      sb_q.push_back(32'hDEAD_BEEF);
      sb_tag.push_back("scratch_rstall");
      ar_issue(4'hC);
      r_collect(4);

      for (int i = 0; i < 5; i++) cap_push(32'hA0 + 32'(i));
      axi_read(4'h4, 32'h0005_0000, "status_5");
      sb_q.push_back(pop_model());
      sb_tag.push_back("data_with_push");
      mdl.push_back(32'hA5);
      check("arready_simul", 32'(ARREADY), 32'd1);
      ARADDR = 4'h8; ARVALID = 1'b1; cap_valid = 1'b1; cap_data = 32'hA5;
      tick();
      ARVALID = 1'b0; cap_valid = 1'b0;
      r_collect(0);
      axi_read(4'h4, 32'h0005_0000, "status_still_5");
      for (int i = 0; i < 5; i++) axi_read(4'h8, pop_model(), "order_drain");

      cap_push(32'hB0); cap_push(32'hB1);
      AWADDR = 4'h0; WDATA = 32'h0000_0003; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      cap_valid = 1'b1; cap_data = 32'hB2;
      tick();
      cap_valid = 1'b0;
      mdl.delete();
      wait_b("clr_push");
      axi_read(4'h4, 32'h0000_0001, "status_clr_push");
      axi_read(4'h8, 32'h0000_0000, "data_after_clr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axi_lite_capture_slave.md
Name: axi_lite_capture_slave

Overview:
AXI4-Lite responder (slave) serving four 32-bit registers: control, status, pop-on-read capture data, and scratch. A local capture port pushes words into an internal FIFO. Software drains the FIFO over AXI through the DATA register. The block sits behind the AXI4-Lite master/interconnect in the block design, at the same end the VIP master targets.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register, addr[1:0] is ignored.
FIFO_DEPTH, 16, capture FIFO depth in words; power of 2, range 2..32768.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
cap_valid  in  1  push strobe; sampled only when CTRL.enable=1
cap_data  in  32  word to push
irq  out  1  level interrupt: CTRL.irq_en & ~empty

Behaviour:
- Reset (async assert, release synchronous to ACLK): all READY/VALID low, RDATA 0, CTRL 0, SCRATCH 0, FIFO empty, overflow 0, irq 0.
- Register map:
  - 0x0 CTRL RW: bit0 enable, bit1 clear (write-1, self-clearing, reads 0), bit2 irq_en.
  - 0x4 STATUS RO: bit0 empty, bit1 full, bit2 overflow (sticky), [31:16] count.
  - 0x8 DATA RO, pop-on-read.
  - 0xC SCRATCH RW.
- Write channel:
  - AWREADY = ~aw_held & ~BVALID; WREADY = ~w_held & ~BVALID. AW and W may arrive in either order or in the same cycle; each is held once accepted.
  - When both are held, the register is updated at the next edge. At that same edge BVALID rises and both holds clear.
  - If AW and W both handshake at edge N, BVALID is high from edge N+1 and stays high until BREADY is sampled high.
  - WSTRB is honoured per byte for CTRL and SCRATCH. Writes to STATUS or DATA are ignored but still return OKAY.
- Read channel:
  - ARREADY = ~RVALID. On the AR handshake at edge N, RDATA is registered and RVALID rises at edge N.
  - RDATA and RVALID are held stable until RREADY. One outstanding read at a time.
- DATA read:
  - Non-empty FIFO: returns the head word and pops at the AR-handshake edge.
  - Empty FIFO: returns 0x00000000, no pop, RRESP OKAY.
- Capture: the FIFO is pushed on any edge with enable & cap_valid & ~full. If full at that point, the word is dropped and overflow sets (sticky).
- Simultaneous push and pop: both happen and count is unchanged. When full, a pop plus push in the same cycle still drops the push, because full is evaluated pre-pop.
- Clear write: flushes the FIFO (count 0) and clears overflow at the write-commit edge. Clear beats a concurrent push or pop. enable and irq_en take the values written in the same transaction.
- STATUS read returns the pre-edge state at the AR-handshake edge.
- Count width is clog2(FIFO_DEPTH)+1, zero-extended into [31:16]. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-transaction aborts all channels immediately; a pending BVALID/RVALID drops asynchronously.

Decomposition:
- Package axi_lite_capture_pkg: register offsets (REG_CTRL=2'd0, REG_STATUS=2'd1, REG_DATA=2'd2, REG_SCRATCH=2'd3), CTRL bit indices, RESP_OKAY constant.
- One sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, flush, dout (head, first-word-fall-through), count, full, empty; async active-low reset.

Test Plan:
- Reset check: release ARESETN; read 0x4 -> 0x00000001; read 0x0 and 0xC -> 0x00000000; BVALID, RVALID and irq are 0.
- Scratch: write 0xC=0x00000001, 0x2, 0x3, 0x4 in sequence, read back each; then WSTRB=4'b0010 with WDATA=0xAABBCCDD over 0x00000004 -> read 0x0000CC04.
- Capture/drain: CTRL=0x5, push 0x11, 0x22, 0x33 -> STATUS=0x00030000 and irq=1; three DATA reads -> 0x11, 0x22, 0x33; STATUS=0x00000001; irq=0; a fourth DATA read -> 0x00000000.
- Overflow: FIFO_DEPTH=16, push 17 words 1..17 -> STATUS=0x00100006; drain yields 1..16; write CTRL=0x3 -> STATUS=0x00000001.
- Handshake ordering: W valid 3 cycles before AW, then AW; BREADY held low 5 cycles -> BVALID stays high, a single commit occurs, no new AWREADY until the B handshake completes; RREADY low 4 cycles -> RDATA stable.
- Simultaneous events: FIFO at count 5, DATA read coincides with a push -> count stays 5 and order is preserved; clear write coinciding with a push -> count 0, the pushed word is lost.
